// File: rtl/trace_capture_unit_if.sv
// trace_capture_unit_if: valid/ready readout port of the trace buffer.
// ENTRY_W is supplied by the instantiator and must match the buffer's entry layout.
interface trace_capture_unit_if #(
  parameter int ENTRY_W = 70
);
  logic               rd_valid_o;
  logic               rd_ready_i;
  logic [ENTRY_W-1:0] rd_data_o;
  logic               rd_last_o;

  modport master (output rd_valid_o, output rd_data_o, output rd_last_o, input rd_ready_i);
  modport slave  (input rd_valid_o, input rd_data_o, input rd_last_o, output rd_ready_i);
endinterface

// File: rtl/trace_capture_unit.sv
// trace_capture_unit: circular PC/writeback trace buffer with PC trigger, manual stop and
// oldest-first valid/ready readout. Define TRACE_TIMESTAMP_EN to add a cycle stamp to each entry.
module trace_capture_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       run_i,
  input  logic [ADDR_W-1:0]          pc_i,
  input  logic                       wb_en_i,
  input  logic [REG_AW-1:0]          wb_addr_i,
  input  logic [DATA_W-1:0]          wb_data_i,
  input  logic                       arm_i,
  input  logic                       stop_i,
  input  logic                       trig_en_i,
  input  logic [ADDR_W-1:0]          trig_pc_i,
  input  logic [CNT_W-1:0]           post_cnt_i,
  trace_capture_unit_if.master       rd,
  output logic [1:0]                 state_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [CNT_W-1:0]           cycle_cnt_o
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = 1 + REG_AW + DATA_W + ADDR_W + CNT_W;
`else
  localparam int ENTRY_W = 1 + REG_AW + DATA_W + ADDR_W;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  state_t             r_state;
  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_idx;
  logic [PTR_W:0]     r_count;
  logic [PTR_W:0]     r_rd_rem;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_post_cnt;
  logic               r_rd_valid;
  logic               r_rd_last;

  logic               w_cap;
  logic               w_match;
  logic               w_beat;
  logic               w_to_done;
  logic [PTR_W-1:0]   w_wr_ptr_nxt;
  logic [PTR_W:0]     w_count_nxt;
  logic [ENTRY_W-1:0] w_entry;

  assign w_cap        = (r_state == S_ARMED || r_state == S_POST) && run_i;
  assign w_match      = trig_en_i && run_i && (pc_i == trig_pc_i);
  assign w_beat       = (r_state == S_DONE) && r_rd_valid && rd.rd_ready_i;
  assign w_wr_ptr_nxt = w_cap ? r_wr_ptr + 1'b1 : r_wr_ptr;
  assign w_count_nxt  = (w_cap && r_count != (PTR_W+1)'(DEPTH)) ? r_count + 1'b1 : r_count;

  // The stamp is the pre-increment counter, so the first capture after arm carries 0.
`ifdef TRACE_TIMESTAMP_EN
  assign w_entry = {r_cycle_cnt, wb_en_i, wb_addr_i, wb_data_i, pc_i};
`else
  assign w_entry = {wb_en_i, wb_addr_i, wb_data_i, pc_i};
`endif

  always_comb begin
    w_to_done = 1'b0;
    if (r_state == S_ARMED || r_state == S_POST) begin
      if (stop_i)
        w_to_done = 1'b1;
      else if (r_state == S_ARMED && w_match && post_cnt_i == '0)
        w_to_done = 1'b1;
      else if (r_state == S_POST && run_i && r_post_cnt == CNT_W'(1))
        w_to_done = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_cap) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_rd_idx    <= '0;
      r_count     <= '0;
      r_rd_rem    <= '0;
      r_cycle_cnt <= '0;
      r_post_cnt  <= '0;
      r_rd_valid  <= 1'b0;
      r_rd_last   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (arm_i) begin
            r_state     <= S_ARMED;
            r_wr_ptr    <= '0;
            r_rd_idx    <= '0;
            r_count     <= '0;
            r_rd_rem    <= '0;
            r_cycle_cnt <= '0;
            r_post_cnt  <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_last   <= 1'b0;
          end else if (w_beat) begin
            r_rd_idx   <= r_rd_idx + 1'b1;
            r_rd_rem   <= r_rd_rem - 1'b1;
            r_rd_valid <= (r_rd_rem != (PTR_W+1)'(1));
            r_rd_last  <= (r_rd_rem == (PTR_W+1)'(2));
          end
        end
        S_ARMED, S_POST: begin
          if (w_cap) begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_count  <= w_count_nxt;
            if (r_cycle_cnt != '1) r_cycle_cnt <= r_cycle_cnt + 1'b1;
          end
          if (w_to_done) begin
            // Readout starts at the oldest held entry, including this cycle's capture.
            r_state    <= S_DONE;
            r_rd_idx   <= w_wr_ptr_nxt - w_count_nxt[PTR_W-1:0];
            r_rd_rem   <= w_count_nxt;
            r_rd_valid <= (w_count_nxt != '0);
            r_rd_last  <= (w_count_nxt == (PTR_W+1)'(1));
          end else if (r_state == S_ARMED && w_match) begin
            r_state    <= S_POST;
            r_post_cnt <= post_cnt_i;
          end else if (r_state == S_POST && run_i) begin
            r_post_cnt <= r_post_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd.rd_valid_o = r_rd_valid;
  assign rd.rd_last_o  = r_rd_last;
  assign rd.rd_data_o  = r_mem[r_rd_idx];
  assign state_o       = r_state;
  assign count_o       = r_count;
  assign cycle_cnt_o   = r_cycle_cnt;
endmodule

// File: tb/tb_trace_capture_unit.sv
// tb_trace_capture_unit: directed scenarios against a queue-based reference model of the trace buffer.
// Stamp checks are compiled in when TRACE_TIMESTAMP_EN is defined.
module tb_trace_capture_unit;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int BASE_W = 1 + REG_AW + DATA_W + ADDR_W;
`ifdef TRACE_TIMESTAMP_EN
  localparam int ENTRY_W = BASE_W + CNT_W;
`else
  localparam int ENTRY_W = BASE_W;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic              run_i = 1'b0;
  logic [ADDR_W-1:0] pc_i = '0;
  logic              wb_en_i = 1'b0;
  logic [REG_AW-1:0] wb_addr_i = '0;
  logic [DATA_W-1:0] wb_data_i = '0;
  logic              arm_i = 1'b0;
  logic              stop_i = 1'b0;
  logic              trig_en_i = 1'b0;
  logic [ADDR_W-1:0] trig_pc_i = '0;
  logic [CNT_W-1:0]  post_cnt_i = '0;
  logic [1:0]        state_o;
  logic [4:0]        count_o;
  logic [CNT_W-1:0]  cycle_cnt_o;

  trace_capture_unit_if #(.ENTRY_W(ENTRY_W)) rd_if ();

  trace_capture_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .run_i(run_i), .pc_i(pc_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .arm_i(arm_i), .stop_i(stop_i),
    .trig_en_i(trig_en_i), .trig_pc_i(trig_pc_i), .post_cnt_i(post_cnt_i),
    .rd(rd_if.master), .state_o(state_o), .count_o(count_o), .cycle_cnt_o(cycle_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: mode follows the documented state numbering; traces kept as queues.
  int                 m_mode = 0;
  logic [ENTRY_W-1:0] m_q[$];
  logic [ENTRY_W-1:0] m_rd[$];
  logic [CNT_W-1:0]   m_cyc = '0;
  int                 m_post = 0;

  always @(posedge clk_i or posedge rst_i) begin
    logic [ENTRY_W-1:0] ent;
    int nxt;
    if (rst_i) begin
      m_mode = 0; m_q.delete(); m_rd.delete(); m_cyc = '0; m_post = 0;
    end else begin
      case (m_mode)
        0: if (arm_i) begin m_mode = 1; m_q.delete(); m_cyc = '0; end
        1, 2: begin
          nxt = m_mode;
          if (run_i) begin
`ifdef TRACE_TIMESTAMP_EN
            ent = {m_cyc, wb_en_i, wb_addr_i, wb_data_i, pc_i};
`else
            ent = {wb_en_i, wb_addr_i, wb_data_i, pc_i};
`endif
            m_q.push_back(ent);
            if (m_q.size() > DEPTH) void'(m_q.pop_front());
            if (m_cyc != '1) m_cyc = m_cyc + 1'b1;
          end
          if (stop_i) nxt = 3;
          else if (m_mode == 1 && trig_en_i && run_i && pc_i == trig_pc_i) begin
            m_post = int'(post_cnt_i);
            nxt = (m_post == 0) ? 3 : 2;
          end else if (m_mode == 2 && run_i) begin
            m_post--;
            if (m_post == 0) nxt = 3;
          end
          if (nxt == 3) m_rd = m_q;
          m_mode = nxt;
        end
        default: begin
          if (arm_i) begin m_mode = 1; m_q.delete(); m_rd.delete(); m_cyc = '0; end
          else if (m_rd.size() > 0 && rd_if.rd_ready_i) void'(m_rd.pop_front());
        end
      endcase
    end
  end

  always @(negedge clk_i) begin
    if (!rst_i) begin
      chk("state", 128'(state_o), 128'(m_mode));
      chk("count", 128'(count_o), 128'(m_q.size()));
      chk("cycle_cnt", 128'(cycle_cnt_o), 128'(m_cyc));
      chk("rd_valid", 128'(rd_if.rd_valid_o), 128'(m_mode == 3 && m_rd.size() > 0));
      chk("rd_last", 128'(rd_if.rd_last_o), 128'(m_mode == 3 && m_rd.size() == 1));
      if (m_mode == 3 && m_rd.size() > 0) chk("rd_data", 128'(rd_if.rd_data_o), 128'(m_rd[0]));
    end
  end

  logic [ENTRY_W-1:0] got[$];
  logic               glast[$];

  function automatic logic [ADDR_W-1:0] pc_of(input logic [ENTRY_W-1:0] e);
    return e[ADDR_W-1:0];
  endfunction

  task automatic step(input logic run, input logic [ADDR_W-1:0] pc, input logic en,
                      input logic [REG_AW-1:0] ad, input logic [DATA_W-1:0] dt);
    run_i = run; pc_i = pc; wb_en_i = en; wb_addr_i = ad; wb_data_i = dt;
    @(posedge clk_i); #1;
    arm_i = 1'b0; stop_i = 1'b0; run_i = 1'b0;
  endtask

  task automatic readout(input int budget);
    bit done = 0;
    got.delete(); glast.delete();
    rd_if.rd_ready_i = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk_i);
      if (!rd_if.rd_valid_o) begin done = 1; break; end
      got.push_back(rd_if.rd_data_o);
      glast.push_back(rd_if.rd_last_o);
    end
    chk("readout_done", 128'(done), 128'(1));
    @(posedge clk_i); #1;
    rd_if.rd_ready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ENTRY_W-1:0] held;
    rd_if.rd_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    chk("rst_state", 128'(state_o), 128'(0));
    chk("rst_count", 128'(count_o), 128'(0));
    chk("rst_valid", 128'(rd_if.rd_valid_o), 128'(0));

    // 1: ten captures then stop, ordered readout
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(1, ADDR_W'(4*i), 1, REG_AW'(i), DATA_W'(3*i));
    stop_i = 1'b1; step(0, 0, 0, 0, 0);
    chk("s1_state", 128'(state_o), 128'(3));
    chk("s1_count", 128'(count_o), 128'(10));
    readout(40);
    chk("s1_beats", 128'(got.size()), 128'(10));
    for (int i = 0; i < got.size(); i++) begin
      chk("s1_pc", 128'(pc_of(got[i])), 128'(4*i));
      chk("s1_wbdata", 128'(got[i][ADDR_W +: DATA_W]), 128'(3*i));
      chk("s1_wbaddr", 128'(got[i][ADDR_W+DATA_W +: REG_AW]), 128'(i));
      chk("s1_wben", 128'(got[i][BASE_W-1]), 128'(1));
      chk("s1_last", 128'(glast[i]), 128'(i == 9));
`ifdef TRACE_TIMESTAMP_EN
      chk("s1_stamp", 128'(got[i][BASE_W +: CNT_W]), 128'(i));
`endif
    end

    // 2: wrap with 20 captures
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, ADDR_W'(4*i), 0, 0, 0);
    stop_i = 1'b1; step(0, 0, 0, 0, 0);
    chk("s2_count", 128'(count_o), 128'(16));
    chk("s2_cycle", 128'(cycle_cnt_o), 128'(20));
    readout(40);
    chk("s2_beats", 128'(got.size()), 128'(16));
    if (got.size() == 16) begin
      chk("s2_first", 128'(pc_of(got[0])), 128'(16));
      chk("s2_lastpc", 128'(pc_of(got[15])), 128'(76));
      chk("s2_lastflag", 128'(glast[15]), 128'(1));
    end

    // 3: trigger at 0x20 with three post entries
    trig_en_i = 1'b1; trig_pc_i = 32'h20; post_cnt_i = 16'd3;
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 14; i++) begin
      step(1, ADDR_W'(4*i), 0, 0, 0);
      if (i == 8) chk("s3_post", 128'(state_o), 128'(2));
    end
    chk("s3_state", 128'(state_o), 128'(3));
    chk("s3_count", 128'(count_o), 128'(12));
    readout(40);
    chk("s3_beats", 128'(got.size()), 128'(12));
    if (got.size() == 12) chk("s3_lastpc", 128'(pc_of(got[11])), 128'(32'h2C));

    // 4: zero post count with gapped run, then stop colliding with trigger
    trig_pc_i = 32'h10; post_cnt_i = 16'd0;
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0);
    step(0, 32'h4, 0, 0, 0);
    step(1, 32'h8, 0, 0, 0);
    step(1, 32'h10, 0, 0, 0);
    chk("s4_state", 128'(state_o), 128'(3));
    chk("s4_count", 128'(count_o), 128'(3));
    readout(40);
    chk("s4_beats", 128'(got.size()), 128'(3));
    if (got.size() == 3) begin
      chk("s4_pc1", 128'(pc_of(got[1])), 128'(32'h8));
      chk("s4_lastpc", 128'(pc_of(got[2])), 128'(32'h10));
    end
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    step(1, 32'h0, 0, 0, 0);
    stop_i = 1'b1; step(1, 32'h10, 0, 0, 0);
    chk("s4b_state", 128'(state_o), 128'(3));
    chk("s4b_count", 128'(count_o), 128'(2));
    trig_en_i = 1'b0;

    // 5: backpressure then arm mid-readout
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, ADDR_W'(32'h100 + 4*i), 1, REG_AW'(i), DATA_W'(i));
    stop_i = 1'b1; step(0, 0, 0, 0, 0);
    @(negedge clk_i); held = rd_if.rd_data_o;
    chk("s5_head", 128'(pc_of(held)), 128'(32'h100));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      chk("s5_hold_data", 128'(rd_if.rd_data_o), 128'(held));
      chk("s5_hold_valid", 128'(rd_if.rd_valid_o), 128'(1));
    end
    @(posedge clk_i); #1;
    rd_if.rd_ready_i = 1'b1;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    rd_if.rd_ready_i = 1'b0;
    chk("s5_third", 128'(pc_of(rd_if.rd_data_o)), 128'(32'h108));
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    chk("s5_armed", 128'(state_o), 128'(1));
    chk("s5_count", 128'(count_o), 128'(0));
    chk("s5_valid", 128'(rd_if.rd_valid_o), 128'(0));

    // 6: async reset mid-POST and mid-readout
    trig_en_i = 1'b1; trig_pc_i = 32'h40; post_cnt_i = 16'd10;
    for (int i = 0; i < 4; i++) step(1, ADDR_W'(32'h38 + 4*i), 0, 0, 0);
    chk("s6_post", 128'(state_o), 128'(2));
    #3 rst_i = 1'b1;
    #1;
    chk("s6_rst_state", 128'(state_o), 128'(0));
    chk("s6_rst_count", 128'(count_o), 128'(0));
    chk("s6_rst_cycle", 128'(cycle_cnt_o), 128'(0));
    @(posedge clk_i); #1 rst_i = 1'b0;
    trig_en_i = 1'b0;
    arm_i = 1'b1; step(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(1, ADDR_W'(4*i), 0, 0, 0);
    stop_i = 1'b1; step(0, 0, 0, 0, 0);
    rd_if.rd_ready_i = 1'b1;
    step(0, 0, 0, 0, 0);
    chk("s6_midread", 128'(rd_if.rd_valid_o), 128'(1));
    #3 rst_i = 1'b1;
    #1;
    chk("s6b_state", 128'(state_o), 128'(0));
    chk("s6b_count", 128'(count_o), 128'(0));
    chk("s6b_valid", 128'(rd_if.rd_valid_o), 128'(0));
    chk("s6b_cycle", 128'(cycle_cnt_o), 128'(0));
    rd_if.rd_ready_i = 1'b0;
    @(posedge clk_i); #1 rst_i = 1'b0;
    repeat (2) @(posedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/trace_capture_unit.md
Name: trace_capture_unit

Overview:
- Parametrised hardware trace buffer for the single-cycle CPU.
- Every cycle the CPU runs, it records PC and register-writeback activity into a circular buffer.
- Supports a PC-match trigger with programmable post-trigger depth and manual stop, then freezes.
- The frozen trace is streamed out, oldest entry first, over a valid/ready port, replacing per-cycle $display dumping for long runs.

Parameters:
ADDR_W, 32, PC width
DATA_W, 32, writeback data width
REG_AW, 5, register index width
DEPTH, 16, trace entries; power of two, >=2
CNT_W, 16, cycle counter width; also post-trigger count width

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  reset, asynchronous, active-high
run_i  input  1  CPU executing this cycle; capture qualifier
pc_i  input  ADDR_W  current PC
wb_en_i  input  1  register write this cycle
wb_addr_i  input  REG_AW  destination register
wb_data_i  input  DATA_W  write data
arm_i  input  1  pulse: clear buffer, start capture
stop_i  input  1  pulse: manual stop
trig_en_i  input  1  enable PC-match trigger
trig_pc_i  input  ADDR_W  trigger PC
post_cnt_i  input  CNT_W  entries to capture after the trigger entry
rd_ready_i  input  1  consumer accepts rd_data_o
rd_valid_o  output  1  unread entry available
rd_data_o  output  ENTRY_W  {wb_en, wb_addr, wb_data, pc}, pc in LSBs
rd_last_o  output  1  rd_data_o is final unread entry
state_o  output  2  IDLE=0, ARMED=1, POST=2, DONE=3
count_o  output  log2(DEPTH)+1  valid entries held
cycle_cnt_o  output  CNT_W  captured cycles since arm, saturating

Behaviour:
- Reset (async, any state): state IDLE; wr_ptr, rd index, count_o, cycle_cnt_o, post counter all 0; rd_valid_o=0, rd_last_o=0. Buffer contents are don't-care.
- Capture: occurs in ARMED or POST on a clock edge with run_i=1. Entry is written at wr_ptr; wr_ptr increments mod DEPTH.
  - count_o increments and saturates at DEPTH; when full, the oldest entry is overwritten.
  - cycle_cnt_o increments and saturates at all-ones.
  - No capture when run_i=0.
- IDLE:
  - arm_i -> ARMED; pointers, count and cycle counter cleared.
  - stop_i ignored.
- ARMED:
  - trig_en_i && run_i && pc_i==trig_pc_i: that cycle's entry is captured.
    - post_cnt_i==0 -> DONE.
    - Otherwise -> POST, with post counter loaded from post_cnt_i.
  - arm_i ignored.
- POST: each capture decrements the post counter. The capture that takes it from 1 to 0 -> DONE. Further matches ignored.
- stop_i in ARMED or POST -> DONE. That cycle's capture (if run_i) still occurs. Stop wins over a simultaneous trigger.
- DONE: capture frozen.
  - Read index starts at oldest entry = (wr_ptr - count) mod DEPTH.
  - rd_valid_o=1 while unread entries remain.
  - rd_data_o is the combinational read at the read index.
  - On rd_valid_o && rd_ready_i: advance index, decrement remaining.
  - rd_last_o = rd_valid_o && remaining==1.
  - rd_data_o holds stable while rd_valid_o && !rd_ready_i.
  - After the last beat, rd_valid_o=0 and the state stays DONE.
  - count_o is not decremented by reads.
- arm_i in DONE (mid-readout or after) aborts readout, clears, -> ARMED. rd_valid_o drops on the next cycle.
- rd_valid_o is 0 in IDLE, ARMED and POST.
- Empty DONE (stop with zero captures): rd_valid_o stays 0.

Optional Feature:
- TRACE_TIMESTAMP_EN defined:
  - Each entry gains cycle_cnt_o value at capture as its MSB field: ENTRY_W = 1+REG_AW+DATA_W+ADDR_W+CNT_W.
  - The first captured entry after arm carries stamp 0.
- Undefined: ENTRY_W = 1+REG_AW+DATA_W+ADDR_W, no stamp storage.

Test Plan:
1. Arm, 10 run cycles pc=0,4..36, wb_en=1, wb_addr=i, wb_data=i*3, then stop -> state DONE, count_o=10; readout with rd_ready_i=1 yields pc 0..36 in order, matching wb fields; rd_last_o only on pc=36.
2. Wrap, DEPTH=16: 20 captures pc=0..76 step 4, stop -> count_o=16, first read pc=16, last pc=76, cycle_cnt_o=20.
3. Trigger: trig_pc_i=0x20, post_cnt_i=3, pc steps 4 from 0 -> POST at 0x20, DONE after 0x2C captured; 0x30 not captured; count_o=12, last entry 0x2C.
4. post_cnt_i=0, trigger at 0x10 with run_i toggling 1,0,1 beforehand -> DONE on trigger cycle; run_i=0 cycles absent; last entry pc=0x10. Stop and trigger in the same cycle -> DONE, entry captured once.
5. Backpressure: hold rd_ready_i=0 for 5 cycles -> rd_data_o and rd_valid_o stable. Pulse arm_i mid-readout -> ARMED, count_o=0, rd_valid_o=0.
6. Assert rst_i asynchronously mid-POST and mid-readout -> immediate IDLE, count_o=0, rd_valid_o=0, cycle_cnt_o=0. With TRACE_TIMESTAMP_EN, scenario 1 stamps read 0..9.
